// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - three-stage approximate unsigned multiplier with valid/ready and result counter
module approx_mul_pipe #(
    parameter int HALF_W = 4,
    parameter int LVL_HH = 3,
    parameter int LVL_LO = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   a,
    input  logic [2*HALF_W-1:0]   b,
    input  logic [3:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   prod,
    output logic [3:0]            out_mode,
    output logic [CNT_W-1:0]      res_cnt
);

    localparam int PW = 2 * HALF_W;
    localparam int FW = 4 * HALF_W;
    localparam logic [PW-1:0] MASK_HH = (LVL_HH >= PW) ? '0 : ~PW'((1 << LVL_HH) - 1);
    localparam logic [PW-1:0] MASK_LO = (LVL_LO >= PW) ? '0 : ~PW'((1 << LVL_LO) - 1);

    logic              en;
    logic              v1_q, v2_q, v3_q;
    logic [PW-1:0]     a_q, b_q;
    logic [3:0]        mode1_q, mode2_q, mode3_q;
    logic [PW-1:0]     hh_q, hl_q, lh_q, ll_q;
    logic [PW-1:0]     hh_d, hl_d, lh_d, ll_d;
    logic [FW-1:0]     prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    always_comb begin
        hh_d = PW'(a_q[PW-1:HALF_W]) * PW'(b_q[PW-1:HALF_W]);
        hl_d = PW'(a_q[PW-1:HALF_W]) * PW'(b_q[HALF_W-1:0]);
        lh_d = PW'(a_q[HALF_W-1:0])  * PW'(b_q[PW-1:HALF_W]);
        ll_d = PW'(a_q[HALF_W-1:0])  * PW'(b_q[HALF_W-1:0]);
        if (mode1_q[3]) hh_d = hh_d & MASK_HH;
        if (mode1_q[2]) hl_d = hl_d & MASK_LO;
        if (mode1_q[1]) lh_d = lh_d & MASK_LO;
        if (mode1_q[0]) ll_d = ll_d & MASK_LO;
    end

    // Truncated sub-products only shrink the sum, so FW bits cannot overflow.
    always_comb begin
        prod_d = (FW'(hh_q) << PW) + (FW'(hl_q) << HALF_W)
               + (FW'(lh_q) << HALF_W) + FW'(ll_q);
        cnt_d  = cnt_q;
        if (v3_q && out_ready) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mode1_q <= '0;
            mode2_q <= '0;
            mode3_q <= '0;
            hh_q    <= '0;
            hl_q    <= '0;
            lh_q    <= '0;
            ll_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (en) begin
                v1_q    <= in_valid;
                a_q     <= a;
                b_q     <= b;
                mode1_q <= mode;
                v2_q    <= v1_q;
                mode2_q <= mode1_q;
                hh_q    <= hh_d;
                hl_q    <= hl_d;
                lh_q    <= lh_d;
                ll_q    <= ll_d;
                v3_q    <= v2_q;
                mode3_q <= mode2_q;
                prod_q  <= prod_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign prod      = prod_q;
    assign out_mode  = mode3_q;
    assign res_cnt   = cnt_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb/tb_approx_mul_pipe.sv - scoreboard bench for approx_mul_pipe
`timescale 1ns/1ps
module tb_approx_mul_pipe;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  m;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [3:0]  mode, out_mode;
    logic [15:0] prod;
    logic [3:0]  res_cnt;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rnd_ready = 1'b0;
    exp_t sb[$];
    int   pop_cyc[$];
    exp_t mon_e;
    logic [15:0] cap_p;
    logic [3:0]  cap_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    approx_mul_pipe #(.HALF_W(4), .LVL_HH(3), .LVL_LO(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .out_mode(out_mode), .res_cnt(res_cnt)
    );

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                            input logic [3:0] m);
        logic [7:0] hh, hl, lh, ll;
        hh = {4'h0, x[7:4]} * {4'h0, y[7:4]};
        hl = {4'h0, x[7:4]} * {4'h0, y[3:0]};
        lh = {4'h0, x[3:0]} * {4'h0, y[7:4]};
        ll = {4'h0, x[3:0]} * {4'h0, y[3:0]};
        if (m[3]) hh = hh & 8'hF8;
        if (m[2]) hl = hl & 8'hF0;
        if (m[1]) lh = lh & 8'hF0;
        if (m[0]) ll = ll & 8'hF0;
        return {hh, 8'h00} + {4'h0, hl, 4'h0} + {4'h0, lh, 4'h0} + {8'h00, ll};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [3:0] m,
                        input logic [15:0] ep);
        exp_t e;
        bit   done;
        done = 1'b0;
        in_valid = 1'b1; a = x; b = y; mode = m;
        for (int t = 0; t < 200 && !done; t++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) begin
                e.p = ep; e.m = m;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        pop_cyc.delete();
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rm;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'(prod), 32'hDEAD_0000);
                    end else begin
                        mon_e = sb.pop_front();
                        check("prod", 32'(prod), 32'(mon_e.p));
                        check("out_mode", 32'(out_mode), 32'(mon_e.m));
                        pop_cyc.push_back(cyc);
                    end
                end
            end
        join_none

        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_prod", 32'(prod), 0);
        check("rst_res_cnt", 32'(res_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // exact product and three-edge latency
        out_ready = 1'b1;
        send(8'hFF, 8'hFF, 4'h0, 16'hFE01);
        check("lat_edge1", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_edge2", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("lat_edge3", 32'(out_valid), 1);
        check("lat_prod", 32'(prod), 32'hFE01);
        drain();

        // approximate quadrants
        send(8'hFF, 8'hFF, 4'hF, 16'hFCE0);
        send(8'h12, 8'h34, 4'h1, 16'h03A0);
        send(8'h12, 8'h34, 4'h0, 16'h03A8);
        drain();

        // back-to-back streaming
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 8'(i * 37 + 5); rb = 8'(255 - i * 29); rm = 4'(i * 3);
            send(ra, rb, rm, ref_mul(ra, rb, rm));
        end
        drain();
        check("stream_count", 32'(pop_cyc.size()), 8);
        if (pop_cyc.size() == 8) check("stream_consecutive", 32'(pop_cyc[7] - pop_cyc[0]), 7);
        check("stream_res_cnt", 32'(res_cnt), 8);

        // backpressure with three items in flight
        do_reset();
        out_ready = 1'b0;
        send(8'hFF, 8'hFF, 4'hF, 16'hFCE0);
        send(8'h12, 8'h34, 4'h1, 16'h03A0);
        send(8'hA5, 8'h3C, 4'h6, ref_mul(8'hA5, 8'h3C, 4'h6));
        check("bp_out_valid", 32'(out_valid), 1);
        cap_p = prod; cap_m = out_mode;
        check("bp_first_prod", 32'(cap_p), 32'hFCE0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_prod_held", 32'(prod), 32'(cap_p));
            check("bp_mode_held", 32'(out_mode), 32'(cap_m));
        end
        drain();
        check("bp_res_cnt", 32'(res_cnt), 3);

        // reset with two items in flight
        do_reset();
        out_ready = 1'b1;
        send(8'h77, 8'h99, 4'h0, ref_mul(8'h77, 8'h99, 4'h0));
        send(8'h21, 8'h43, 4'h2, ref_mul(8'h21, 8'h43, 4'h2));
        do_reset();
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_res_cnt", 32'(res_cnt), 0);
        check("mid_rst_prod", 32'(prod), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("mid_rst_no_stale", 32'(out_valid), 0);
        end

        // random traffic and counter wrap (4-bit counter)
        rnd_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rm = 4'($urandom);
            send(ra, rb, rm, ref_mul(ra, rb, rm));
        end
        rnd_ready = 1'b0;
        drain();
        check("wrap_pre", 32'(res_cnt), 15);
        send(8'hF0, 8'h0F, 4'hA, ref_mul(8'hF0, 8'h0F, 4'hA));
        drain();
        check("wrap_zero", 32'(res_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
